// File: rtl/dds_phase_accumulator.sv
// Phase accumulator for the DDS core: produces the waveform ROM read address each clock,
// with a handshaked frequency control word applied immediately or phase-continuously at wrap.
module dds_phase_accumulator #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ACC_W-1:0]  fcw_in,
    input  logic              fcw_valid,
    input  logic              fcw_sync,
    output logic              fcw_ready,
    input  logic [ADDR_W-1:0] phase_ofs,
    input  logic              phase_clr,
    output logic [ADDR_W-1:0] raddr,
    output logic              addr_valid,
    output logic              dout_valid,
    output logic              wrap
);

    typedef enum logic [0:0] {StReady, StPending} fcw_state_e;

    fcw_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  fcw_active_q, fcw_active_d;
    logic [ACC_W-1:0]  shadow_q, shadow_d;
    logic              sync_q, sync_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              addr_valid_q, addr_valid_d;
    logic              dout_valid_q;
    logic              wrap_q, wrap_d;

    logic [ACC_W-1:0]  acc_sum;
    logic              carry;
    logic              ready_st;

    // Accumulator step and address generation; clear wins over enable.
    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, fcw_active_q};
        acc_d        = acc_q;
        raddr_d      = raddr_q;
        wrap_d       = 1'b0;
        addr_valid_d = 1'b0;
        if (phase_clr) begin
            acc_d        = '0;
            raddr_d      = phase_ofs;
            addr_valid_d = 1'b1;
        end else if (en) begin
            acc_d        = acc_sum;
            wrap_d       = carry;
            raddr_d      = acc_sum[ACC_W-1 -: ADDR_W] + phase_ofs;
            addr_valid_d = 1'b1;
        end
    end

    // FCW handshake: accept into shadow, then apply now or at the next wrap / clear.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        sync_d       = sync_q;
        fcw_active_d = fcw_active_q;
        ready_st     = 1'b0;
        unique case (state_q)
            StReady: begin
                ready_st = 1'b1;
                if (fcw_valid) begin
                    shadow_d = fcw_in;
                    sync_d   = fcw_sync;
                    state_d  = StPending;
                end
            end
            StPending: begin
                // The wrapping step itself still uses the old word.
                if (!sync_q || phase_clr || (en && carry)) begin
                    fcw_active_d = shadow_q;
                    state_d      = StReady;
                end
            end
            default: state_d = StReady;
        endcase
    end

    // Ready is held low while reset is asserted so nothing can be offered during reset.
    assign fcw_ready = ready_st & rst_n;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StReady;
            acc_q        <= '0;
            fcw_active_q <= '0;
            shadow_q     <= '0;
            sync_q       <= 1'b0;
            raddr_q      <= '0;
            addr_valid_q <= 1'b0;
            dout_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fcw_active_q <= fcw_active_d;
            shadow_q     <= shadow_d;
            sync_q       <= sync_d;
            raddr_q      <= raddr_d;
            addr_valid_q <= addr_valid_d;
            dout_valid_q <= addr_valid_q;
            wrap_q       <= wrap_d;
        end
    end

    assign raddr      = raddr_q;
    assign addr_valid = addr_valid_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator: hand-computed address/handshake sequences.
module tb_dds_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] fcw_in;
    logic        fcw_valid;
    logic        fcw_sync;
    logic        fcw_ready;
    logic [11:0] phase_ofs;
    logic        phase_clr;
    logic [11:0] raddr;
    logic        addr_valid;
    logic        dout_valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int wraps;

    dds_phase_accumulator #(
        .ACC_W  (32),
        .ADDR_W (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fcw_in     (fcw_in),
        .fcw_valid  (fcw_valid),
        .fcw_sync   (fcw_sync),
        .fcw_ready  (fcw_ready),
        .phase_ofs  (phase_ofs),
        .phase_clr  (phase_clr),
        .raddr      (raddr),
        .addr_valid (addr_valid),
        .dout_valid (dout_valid),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        fcw_in    = 32'hDEAD_BEEF;
        fcw_valid = 1'b1;
        fcw_sync  = 1'b0;
        phase_ofs = 12'h000;
        phase_clr = 1'b0;

        // Reset with a word offered: everything low, nothing accepted.
        repeat (3) step();
        check("rst_raddr", {20'd0, raddr}, 32'h0);
        check("rst_addr_valid", {31'd0, addr_valid}, 32'h0);
        check("rst_dout_valid", {31'd0, dout_valid}, 32'h0);
        check("rst_wrap", {31'd0, wrap}, 32'h0);
        check("rst_ready", {31'd0, fcw_ready}, 32'h0);
        rst_n     = 1'b1;
        fcw_valid = 1'b0;
        #1;
        check("rel_ready", {31'd0, fcw_ready}, 32'h1);
        en = 1'b1;
        step();
        step();
        check("rst_no_accept_raddr", {20'd0, raddr}, 32'h0);
        check("rst_no_accept_wrap", {31'd0, wrap}, 32'h0);

        // Immediate load of step 1, full 4096-cycle period.
        fcw_in    = 32'h0010_0000;
        fcw_valid = 1'b1;
        fcw_sync  = 1'b0;
        en        = 1'b0;
        step();
        check("imm_pending_ready", {31'd0, fcw_ready}, 32'h0);
        fcw_valid = 1'b0;
        en        = 1'b1;
        step();
        check("imm_apply_raddr", {20'd0, raddr}, 32'h0);
        check("imm_apply_ready", {31'd0, fcw_ready}, 32'h1);
        check("imm_apply_av", {31'd0, addr_valid}, 32'h1);
        check("imm_apply_dv", {31'd0, dout_valid}, 32'h0);
        step();
        check("step1_raddr1", {20'd0, raddr}, 32'h1);
        check("step1_dv", {31'd0, dout_valid}, 32'h1);
        step();
        check("step1_raddr2", {20'd0, raddr}, 32'h2);
        repeat (4093) step();
        check("step1_fff", {20'd0, raddr}, 32'hFFF);
        check("step1_fff_wrap", {31'd0, wrap}, 32'h0);
        step();
        check("step1_wrap_raddr", {20'd0, raddr}, 32'h0);
        check("step1_wrap", {31'd0, wrap}, 32'h1);
        wraps = 0;
        for (int i = 0; i < 4096; i++) begin
            step();
            if (wrap) wraps++;
        end
        check("period_wraps", wraps, 32'd1);
        check("period_end_raddr", {20'd0, raddr}, 32'h0);
        check("period_end_wrap", {31'd0, wrap}, 32'h1);

        // Nyquist word.
        fcw_in    = 32'h8000_0000;
        fcw_valid = 1'b1;
        phase_clr = 1'b1;
        step();
        check("nyq_clr_raddr", {20'd0, raddr}, 32'h0);
        fcw_valid = 1'b0;
        phase_clr = 1'b0;
        en        = 1'b0;
        step();
        check("nyq_hold_av", {31'd0, addr_valid}, 32'h0);
        en = 1'b1;
        step();
        check("nyq_c_raddr", {20'd0, raddr}, 32'h800);
        check("nyq_c_wrap", {31'd0, wrap}, 32'h0);
        check("nyq_c_dv", {31'd0, dout_valid}, 32'h0);
        step();
        check("nyq_d_raddr", {20'd0, raddr}, 32'h000);
        check("nyq_d_wrap", {31'd0, wrap}, 32'h1);
        check("nyq_d_dv", {31'd0, dout_valid}, 32'h1);
        step();
        check("nyq_e_raddr", {20'd0, raddr}, 32'h800);
        check("nyq_e_wrap", {31'd0, wrap}, 32'h0);
        step();
        check("nyq_f_raddr", {20'd0, raddr}, 32'h000);
        check("nyq_f_wrap", {31'd0, wrap}, 32'h1);

        // Step 16, then a sync load of step 32 at raddr 0x500.
        fcw_in    = 32'h0100_0000;
        fcw_valid = 1'b1;
        fcw_sync  = 1'b0;
        phase_clr = 1'b1;
        step();
        fcw_valid = 1'b0;
        phase_clr = 1'b0;
        en        = 1'b0;
        step();
        en = 1'b1;
        repeat (80) step();
        check("s16_500", {20'd0, raddr}, 32'h500);
        fcw_in    = 32'h0200_0000;
        fcw_valid = 1'b1;
        fcw_sync  = 1'b1;
        step();
        check("sync_ready_low", {31'd0, fcw_ready}, 32'h0);
        check("sync_510", {20'd0, raddr}, 32'h510);
        fcw_valid = 1'b0;
        repeat (174) step();
        check("sync_ff0", {20'd0, raddr}, 32'hFF0);
        check("sync_ff0_ready", {31'd0, fcw_ready}, 32'h0);
        step();
        check("sync_wrap_raddr", {20'd0, raddr}, 32'h000);
        check("sync_wrap", {31'd0, wrap}, 32'h1);
        check("sync_wrap_ready", {31'd0, fcw_ready}, 32'h1);
        step();
        check("s32_020", {20'd0, raddr}, 32'h020);
        step();
        check("s32_040", {20'd0, raddr}, 32'h040);

        // Phase offset and clear.
        phase_ofs = 12'h400;
        phase_clr = 1'b1;
        step();
        check("clr_ofs_raddr", {20'd0, raddr}, 32'h400);
        check("clr_ofs_wrap", {31'd0, wrap}, 32'h0);
        check("clr_ofs_av", {31'd0, addr_valid}, 32'h1);
        phase_clr = 1'b0;
        repeat (96) step();
        check("ofs_c00", {20'd0, raddr}, 32'h000);
        repeat (31) step();
        check("ofs_fe0", {20'd0, raddr}, 32'h3E0);
        phase_clr = 1'b1;
        step();
        check("clr_carry_raddr", {20'd0, raddr}, 32'h400);
        check("clr_carry_wrap", {31'd0, wrap}, 32'h0);
        phase_clr = 1'b0;

        // Enable pattern 1,0,0,1.
        step();
        check("en1_raddr", {20'd0, raddr}, 32'h420);
        check("en1_av", {31'd0, addr_valid}, 32'h1);
        en = 1'b0;
        step();
        check("en0a_raddr", {20'd0, raddr}, 32'h420);
        check("en0a_av", {31'd0, addr_valid}, 32'h0);
        step();
        check("en0b_raddr", {20'd0, raddr}, 32'h420);
        check("en0b_dv", {31'd0, dout_valid}, 32'h0);
        en = 1'b1;
        step();
        check("en1b_raddr", {20'd0, raddr}, 32'h440);
        check("en1b_av", {31'd0, addr_valid}, 32'h1);
        check("en1b_dv", {31'd0, dout_valid}, 32'h0);

        // Sync word waits with en=0 until a clear releases it.
        en        = 1'b0;
        fcw_in    = 32'h0010_0000;
        fcw_valid = 1'b1;
        fcw_sync  = 1'b1;
        step();
        fcw_valid = 1'b0;
        check("wait_ready0", {31'd0, fcw_ready}, 32'h0);
        repeat (5) step();
        check("wait_ready_still0", {31'd0, fcw_ready}, 32'h0);
        check("wait_raddr", {20'd0, raddr}, 32'h440);
        phase_clr = 1'b1;
        step();
        check("release_raddr", {20'd0, raddr}, 32'h400);
        check("release_ready", {31'd0, fcw_ready}, 32'h1);
        phase_clr = 1'b0;
        en        = 1'b1;
        step();
        check("release_step1", {20'd0, raddr}, 32'h401);
        step();
        check("release_step2", {20'd0, raddr}, 32'h402);

        // Reset during a sync pending word drops it.
        en        = 1'b0;
        fcw_in    = 32'h0400_0000;
        fcw_valid = 1'b1;
        fcw_sync  = 1'b1;
        step();
        fcw_valid = 1'b0;
        check("rp_pending_ready", {31'd0, fcw_ready}, 32'h0);
        rst_n = 1'b0;
        step();
        check("rp_rst_ready", {31'd0, fcw_ready}, 32'h0);
        check("rp_rst_raddr", {20'd0, raddr}, 32'h0);
        check("rp_rst_av", {31'd0, addr_valid}, 32'h0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("rp_after_raddr", {20'd0, raddr}, 32'h400);
        check("rp_after_ready", {31'd0, fcw_ready}, 32'h1);
        step();
        check("rp_after2_raddr", {20'd0, raddr}, 32'h400);
        check("rp_after2_wrap", {31'd0, wrap}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
